load_store_mem_ctrl: RTL

- Memory-side controller directly downstream of the MEM stage.
- Takes the stage's address, aluop and store data, and runs byte-serial transfers on the shared 8-bit RAM port after winning arbitration against instruction fetch.
- Returns a one-cycle done pulse. For loads it also returns the raw little-endian 32-bit word.
- The MEM stage performs sign/zero extension and holds its stall request until done.

---
 rtl/load_store_mem_ctrl_pkg.sv | 28 ++
 rtl/load_store_mem_ctrl_if.sv | 34 +++
 rtl/load_store_mem_ctrl_ls_op_decode.sv | 39 +++
 rtl/load_store_mem_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/load_store_mem_ctrl_pkg.sv
// Shared aluop codes, bus types and state encoding
// for the load/store memory controller.
package load_store_mem_ctrl_pkg;

  localparam int RAM_AW_DEF = 17;

  typedef logic [7:0] aluop_t;
  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  localparam aluop_t EXE_NOP_OP = 8'b00000000;
  localparam aluop_t EXE_ADD_OP = 8'b00100000;
  localparam aluop_t EXE_LB_OP  = 8'b11100000;
  localparam aluop_t EXE_LH_OP  = 8'b11100001;
  localparam aluop_t EXE_LW_OP  = 8'b11100011;
  localparam aluop_t EXE_LBU_OP = 8'b11100100;
  localparam aluop_t EXE_LHU_OP = 8'b11100101;
  localparam aluop_t EXE_SB_OP  = 8'b11101000;
  localparam aluop_t EXE_SH_OP  = 8'b11101001;
  localparam aluop_t EXE_SW_OP  = 8'b11101011;

endpackage

// File: rtl/load_store_mem_ctrl_if.sv
// Byte-wide shared RAM port with arbiter grant.
// master = controller side, slave = RAM/arbiter side.
interface load_store_mem_ctrl_if
  import load_store_mem_ctrl_pkg::*;
#(
  parameter int AW = RAM_AW_DEF
) ();

  logic          ram_req;
  logic          ram_gnt;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  byte_t         ram_wdata;
  byte_t         ram_rdata;

  modport master (
    output ram_req,
    output ram_addr,
    output ram_we,
    output ram_wdata,
    input  ram_gnt,
    input  ram_rdata
  );

  modport slave (
    input  ram_req,
    input  ram_addr,
    input  ram_we,
    input  ram_wdata,
    output ram_gnt,
    output ram_rdata
  );

endinterface

// File: rtl/load_store_mem_ctrl_ls_op_decode.sv
// Maps an aluop to {valid, is_store, byte count};
// shared with the RAM arbiter.
module ls_op_decode
  import load_store_mem_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  output logic       valid,
  output logic       is_store,
  output logic [2:0] n
);

  always_comb begin
    valid    = 1'b1;
    is_store = 1'b0;
    n        = 3'd1;
    unique case (aluop)
      EXE_LB_OP, EXE_LBU_OP: n = 3'd1;
      EXE_LH_OP, EXE_LHU_OP: n = 3'd2;
      EXE_LW_OP:             n = 3'd4;
      EXE_SB_OP: begin
        is_store = 1'b1;
        n        = 3'd1;
      end
      EXE_SH_OP: begin
        is_store = 1'b1;
        n        = 3'd2;
      end
      EXE_SW_OP: begin
        is_store = 1'b1;
        n        = 3'd4;
      end
      default: begin
        valid = 1'b0;
        n     = 3'd0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_mem_ctrl.sv
// MEM-stage load/store controller: byte-serial
// transfers on the shared 8-bit RAM port.
module load_store_mem_ctrl
  import load_store_mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  aluop_t      mem_aluop_i,
  input  logic [31:0] rt_data_i,
  output logic        load_store_mem_ctrl_done,
  output logic [31:0] rdata,
  load_store_mem_ctrl_if.master ram
);

  ctrl_state_t       state, state_nx;
  logic [RAM_AW-1:0] addr_q;
  logic [2:0]        n_q;
  logic              st_q;
  logic [31:0]       wd_q;
  logic [2:0]        issue_cnt;
  logic [2:0]        recv_cnt;
  logic              issued_q;
  logic              dec_valid;
  logic              dec_store;
  logic [2:0]        dec_n;
  logic              accept;
  logic              issue;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^mem_addr_i[31:RAM_AW];

  ls_op_decode u_dec (
    .aluop    (mem_aluop_i),
    .valid    (dec_valid),
    .is_store (dec_store),
    .n        (dec_n)
  );

  assign accept = (state == IDLE) && dec_valid;

  always_comb begin
    state_nx                 = state;
    issue                    = 1'b0;
    ram.ram_req              = 1'b0;
    ram.ram_addr             = '0;
    ram.ram_we               = 1'b0;
    ram.ram_wdata            = '0;
    load_store_mem_ctrl_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (dec_valid) state_nx = REQ;
      end
      REQ: begin
        ram.ram_req = 1'b1;
        if (ram.ram_gnt) state_nx = XFER;
      end
      XFER: begin
        // loads drop the request while the last byte is in flight
        ram.ram_req = (issue_cnt < n_q);
        issue       = ram.ram_req && ram.ram_gnt;
        if (issue) begin
          ram.ram_addr = addr_q + RAM_AW'(issue_cnt);
          ram.ram_we   = st_q;
          if (st_q)
            ram.ram_wdata =
              wd_q[{issue_cnt[1:0], 3'b000} +: 8];
        end
        if (st_q && issue &&
            issue_cnt == n_q - 3'd1)
          state_nx = DONE;
        if (!st_q && issued_q &&
            recv_cnt == n_q - 3'd1)
          state_nx = DONE;
      end
      DONE: begin
        load_store_mem_ctrl_done = 1'b1;
        state_nx                 = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      n_q       <= '0;
      st_q      <= 1'b0;
      wd_q      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      issued_q  <= 1'b0;
      rdata     <= '0;
    end else begin
      state    <= state_nx;
      issued_q <= issue && !st_q;
      if (accept) begin
        addr_q    <= mem_addr_i[RAM_AW-1:0];
        n_q       <= dec_n;
        st_q      <= dec_store;
        wd_q      <= rt_data_i;
        issue_cnt <= '0;
        recv_cnt  <= '0;
        rdata     <= '0;
      end
      if (issue) issue_cnt <= issue_cnt + 3'd1;
      if (issued_q) begin
        rdata[{recv_cnt[1:0], 3'b000} +: 8]
          <= ram.ram_rdata;
        recv_cnt <= recv_cnt + 3'd1;
      end
    end
  end

endmodule
